// File: rtl/gsim_sched.sv
// Row sequencer for the single GSIM PE: Gauss-Seidel sweeps with early stop
// on tolerance, followed by an N-row output phase.
module gsim_sched #(
    parameter int N        = 16,
    parameter int MAX_ITER = 80,
    parameter int PE_LAT   = 3,
    parameter int RW       = $clog2(N),
    parameter int IW       = $clog2(MAX_ITER)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          abort,
    input  logic [31:0]   tol_in,
    input  logic [31:0]   pe_out,
    input  logic [31:0]   x_old,
    output logic          busy,
    output logic          issue_valid,
    output logic [RW-1:0] issue_row,
    output logic [5:0]    nbr_mask,
    output logic          wb_valid,
    output logic [RW-1:0] wb_row,
    output logic [IW-1:0] iter_cnt,
    output logic [31:0]   max_delta,
    output logic          out_valid,
    output logic [RW-1:0] out_row,
    output logic          done,
    output logic          converged
);

    localparam int CW = $clog2(PE_LAT + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_OUT   = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [RW-1:0] row_q, row_d;
    logic [CW-1:0] cyc_q, cyc_d;
    logic [IW-1:0] iter_q, iter_d;
    logic [31:0]   maxd_q, maxd_d;
    logic [31:0]   tol_q, tol_d;
    logic          conv_q, conv_d;

    logic [32:0] diff, diff_neg;
    logic [31:0] delta, m;
    logic        issue, wb, last_row;
    logic [5:0]  mask_c;

    // 33-bit signed difference; its magnitude always fits in 32 unsigned bits
    assign diff     = {pe_out[31], pe_out} - {x_old[31], x_old};
    assign diff_neg = 33'd0 - diff;
    assign delta    = diff[32] ? diff_neg[31:0] : diff[31:0];
    assign m        = (delta > maxd_q) ? delta : maxd_q;

    assign issue    = (state_q == S_RUN) && (cyc_q == '0);
    assign wb       = ((state_q == S_RUN) || (state_q == S_DRAIN))
                      && (cyc_q == CW'(PE_LAT));
    assign last_row = (row_q == RW'(N - 1));

    always_comb begin
        mask_c = '0;
        if (issue) begin
            for (int k = 0; k < 3; k++) begin
                mask_c[k]   = (int'(row_q) >= k + 1);
                mask_c[k+3] = (int'(row_q) + k + 1 <= N - 1);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        cyc_d   = cyc_q;
        iter_d  = iter_q;
        maxd_d  = maxd_q;
        tol_d   = tol_q;
        conv_d  = conv_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    tol_d   = tol_in;
                    iter_d  = '0;
                    maxd_d  = '0;
                    conv_d  = 1'b0;
                    row_d   = '0;
                    cyc_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (wb) begin
                    maxd_d = m;
                    row_d  = row_q + RW'(1);
                    cyc_d  = '0;
                end else begin
                    cyc_d = cyc_q + CW'(1);
                end
                if (issue && last_row) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (wb) begin
                    row_d = '0;
                    cyc_d = '0;
                    if (m <= tol_q) begin
                        conv_d  = 1'b1;
                        maxd_d  = m;
                        state_d = S_OUT;
                    end else if (iter_q == IW'(MAX_ITER - 1)) begin
                        maxd_d  = m;
                        state_d = S_OUT;
                    end else begin
                        iter_d  = iter_q + IW'(1);
                        maxd_d  = '0;
                        state_d = S_RUN;
                    end
                end else begin
                    cyc_d = cyc_q + CW'(1);
                end
            end
            S_OUT: begin
                if (last_row) begin
                    row_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    row_d = row_q + RW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Abort drops any in-flight write-back and the pending done pulse
        if (abort) begin
            state_d = S_IDLE;
            row_d   = '0;
            cyc_d   = '0;
            conv_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            row_q   <= '0;
            cyc_q   <= '0;
            iter_q  <= '0;
            maxd_q  <= '0;
            tol_q   <= '0;
            conv_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            cyc_q   <= cyc_d;
            iter_q  <= iter_d;
            maxd_q  <= maxd_d;
            tol_q   <= tol_d;
            conv_q  <= conv_d;
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign issue_valid = issue;
    assign issue_row   = row_q;
    assign nbr_mask    = mask_c;
    assign wb_valid    = wb;
    assign wb_row      = row_q;
    assign iter_cnt    = iter_q;
    assign max_delta   = maxd_q;
    assign out_valid   = (state_q == S_OUT);
    assign out_row     = row_q;
    assign done        = (state_q == S_OUT) && last_row;
    assign converged   = conv_q;

endmodule
